// File: rtl/keyexp_seq.sv
// rtl/keyexp_seq.sv - AES key-expansion sequencer with a readable round-key buffer
//
// keyexp_sbox : combinational AES S-box
//   a  in  8 : byte in
//   y  out 8 : S-box substitution of a
//
// keyexp_seq  : expands a 128/192/256-bit key one word per cycle into a buffer
//   clk, rst                   clock, asynchronous active-high reset
//   i_valid, o_ready           key load handshake
//   i_mode                     key size (0=128, 1=192, 2=256, 3=reserved)
//   i_key                      key, word 0 in the MSBs, unused low words ignored
//   o_wvalid, o_widx, o_w      one-cycle strobe with index and value of each new word
//   o_done                     level: full schedule for the last accepted key stored
//   o_err                      one-cycle strobe: reserved mode accepted
//   i_rd_round                 round-key read address
//   o_rd_key, o_rd_valid       combinational round-key read data and validity

module keyexp_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module keyexp_seq #(
    parameter int WORD   = 32,
    parameter int NB     = 4,
    parameter int MAX_NK = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [1:0]             i_mode,
    input  logic [WORD*MAX_NK-1:0] i_key,
    output logic                   o_wvalid,
    output logic [5:0]             o_widx,
    output logic [WORD-1:0]        o_w,
    output logic                   o_done,
    output logic                   o_err,
    input  logic [3:0]             i_rd_round,
    output logic [WORD*NB-1:0]     o_rd_key,
    output logic                   o_rd_valid
);
    localparam int KW    = (MAX_NK > 1) ? $clog2(MAX_NK) : 1;
    // o_widx is 6 bits wide, so the buffer covers the whole index space and any
    // 4-bit read address maps inside it.
    localparam int DEPTH = 64;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t     state;
    logic [1:0] mode;
    logic [6:0] wcnt;
    logic [5:0] idx;
    logic [3:0] kcnt;   // i mod NK, kept as a wrap counter
    logic [7:0] rcon;

    logic [WORD-1:0] kbuf  [DEPTH];
    logic [WORD-1:0] win   [MAX_NK];  // win[k] holds w[i-1-k]
    logic [WORD-1:0] key_w [MAX_NK];

    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            2'd0:    nk_of = 4'd4;
            2'd1:    nk_of = 4'd6;
            default: nk_of = 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (m)
            2'd0:    nr_of = 4'd10;
            2'd1:    nr_of = 4'd12;
            default: nr_of = 4'd14;
        endcase
    endfunction

    logic [3:0] nk_in, nk_cur, nr_cur, nk_m1;
    logic [5:0] last_idx;
    logic       legal, load_en, exp_en;

    assign nk_in    = nk_of(i_mode);
    assign nk_cur   = nk_of(mode);
    assign nr_cur   = nr_of(mode);
    assign nk_m1    = nk_cur - 4'd1;
    assign last_idx = 6'(NB * (int'(nr_cur) + 1) - 1);
    assign o_ready  = (state != S_EXPAND);
    assign legal    = (i_mode != 2'd3);
    // Gated with rst so the unreset storage never loads while reset is held.
    assign load_en  = !rst && i_valid && o_ready && legal;
    assign exp_en   = !rst && (state == S_EXPAND);

    for (genvar j = 0; j < MAX_NK; j++) begin : g_key
        assign key_w[j] = i_key[WORD*(MAX_NK-j)-1 -: WORD];
    end

    logic [WORD-1:0] prev_w, old_w, rot_w, sub_in, sub_out, new_w;
    logic [7:0]      rcon_next;
    logic            is_rot, is_sub;

    for (genvar b = 0; b < WORD/8; b++) begin : g_sbox
        keyexp_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .y (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        prev_w    = win[0];
        old_w     = win[nk_m1[KW-1:0]];
        rot_w     = {prev_w[WORD-9:0], prev_w[WORD-1 -: 8]};
        is_rot    = (kcnt == 4'd0);
        // The extra SubWord step only exists for 256-bit keys, half way through each NK block.
        is_sub    = (nk_cur == 4'd8) && (kcnt == 4'd4);
        sub_in    = is_rot ? rot_w : prev_w;
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (is_rot) begin
            new_w = old_w ^ sub_out ^ {rcon, {(WORD-8){1'b0}}};
        end else if (is_sub) begin
            new_w = old_w ^ sub_out;
        end else begin
            new_w = old_w ^ prev_w;
        end
    end

    logic [7:0] rd_last;

    always_comb begin
        o_rd_key = '0;
        for (int k = 0; k < NB; k++) begin
            o_rd_key[WORD*(NB-k)-1 -: WORD] = kbuf[6'(NB * int'(i_rd_round) + k)];
        end
        rd_last    = 8'(NB * int'(i_rd_round) + NB - 1);
        o_rd_valid = (rd_last < {1'b0, wcnt}) && (i_rd_round <= nr_cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mode     <= 2'd0;
            wcnt     <= 7'd0;
            idx      <= 6'd0;
            kcnt     <= 4'd0;
            rcon     <= 8'h01;
            o_wvalid <= 1'b0;
            o_widx   <= 6'd0;
            o_w      <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_wvalid <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_valid) begin
                        o_done <= 1'b0;
                        if (!legal) begin
                            o_err <= 1'b1;
                            wcnt  <= 7'd0;
                            state <= S_IDLE;
                        end else begin
                            mode  <= i_mode;
                            wcnt  <= {3'b0, nk_in};
                            idx   <= {2'b0, nk_in};
                            kcnt  <= 4'd0;
                            rcon  <= 8'h01;
                            state <= S_EXPAND;
                        end
                    end else if (state == S_DONE) begin
                        // Raised on the first DONE cycle, one cycle after the last word strobe.
                        o_done <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    o_wvalid <= 1'b1;
                    o_widx   <= idx;
                    o_w      <= new_w;
                    wcnt     <= wcnt + 7'd1;
                    idx      <= idx + 6'd1;
                    kcnt     <= (kcnt == nk_m1) ? 4'd0 : kcnt + 4'd1;
                    if (is_rot) begin
                        rcon <= rcon_next;
                    end
                    if (idx == last_idx) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer and window carry no reset; validity is tracked by wcnt alone.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(nk_in)) begin
                    kbuf[6'(k)] <= key_w[k];
                    win[k]      <= key_w[KW'(int'(nk_in) - 1 - k)];
                end
            end
        end else if (exp_en) begin
            kbuf[idx] <= new_w;
            win[0]    <= new_w;
            for (int k = 1; k < MAX_NK; k++) begin
                win[k] <= win[k-1];
            end
        end
    end
endmodule

// File: tb/tb_keyexp_seq.sv
// tb/tb_keyexp_seq.sv - self-checking bench for keyexp_seq
module tb_keyexp_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [1:0]   i_mode = 2'd0;
    logic [255:0] i_key = '0;
    logic         o_wvalid;
    logic [5:0]   o_widx;
    logic [31:0]  o_w;
    logic         o_done;
    logic         o_err;
    logic [3:0]   i_rd_round = 4'd0;
    logic [127:0] o_rd_key;
    logic         o_rd_valid;

    always #5 clk = ~clk;

    keyexp_seq #(.WORD(32), .NB(4), .MAX_NK(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mode     (i_mode),
        .i_key      (i_key),
        .o_wvalid   (o_wvalid),
        .o_widx     (o_widx),
        .o_w        (o_w),
        .o_done     (o_done),
        .o_err      (o_err),
        .i_rd_round (i_rd_round),
        .o_rd_key   (o_rd_key),
        .o_rd_valid (o_rd_valid)
    );

    // Field order: mode, key, nk, nr, inject cycle (-1 none), three {index, word} probes,
    // round-key read address and expected round key.
    typedef struct {
        logic [1:0]   mode;
        logic [255:0] key;
        int           nk;
        int           nr;
        int           inject;
        logic [5:0]   ia;
        logic [31:0]  wa;
        logic [5:0]   ib;
        logic [31:0]  wb;
        logic [5:0]   ic;
        logic [31:0]  wc;
        logic [3:0]   rk_round;
        logic [127:0] rk;
    } vec_t;

    vec_t        vecs [3];
    logic [31:0] cap  [64];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic run_key(input vec_t v);
        int  exp_n;
        int  expidx;
        int  nstb;
        bit  first_ok;
        bit  seq_ok;
        bit  done_ok;
        bit  rd_ok;
        bit  finished;
        exp_n    = 4 * (v.nr + 1) - v.nk;
        expidx   = v.nk;
        nstb     = 0;
        first_ok = 1'b0;
        seq_ok   = 1'b1;
        done_ok  = 1'b1;
        rd_ok    = 1'b1;
        finished = 1'b0;
        for (int k = 0; k < 64; k++) cap[k] = '0;
        i_rd_round = 4'(v.nr);
        i_valid    = 1'b1;
        i_mode     = v.mode;
        i_key      = v.key;
        @(negedge clk);
        i_valid = 1'b0;
        check("accept_state", {o_ready, o_wvalid, o_done}, 3'b000);
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            if (cyc == v.inject) begin
                i_valid = 1'b1;
                i_mode  = 2'd0;
                i_key   = {8{32'hdeadbeef}};
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) first_ok = o_wvalid && (o_widx == 6'(v.nk));
            if (o_wvalid) begin
                cap[o_widx] = o_w;
                if (o_widx != 6'(expidx)) seq_ok = 1'b0;
                if (o_done) done_ok = 1'b0;
                expidx++;
                nstb++;
            end else begin
                finished = 1'b1;
                if (!o_done) done_ok = 1'b0;
            end
            if (o_rd_valid !== (nstb == exp_n)) rd_ok = 1'b0;
        end
        i_valid = 1'b0;
        if (!finished) done_ok = 1'b0;
        check("first_strobe", first_ok, 1'b1);
        check("strobe_count", nstb, exp_n);
        check("index_sequence", seq_ok, 1'b1);
        check("done_timing", done_ok, 1'b1);
        check("rd_valid_track", rd_ok, 1'b1);
    endtask

    task automatic apply_vec(input int vi);
        vec_t v;
        v = vecs[vi];
        run_key(v);
        check("word_a", cap[v.ia], v.wa);
        check("word_b", cap[v.ib], v.wb);
        check("word_c", cap[v.ic], v.wc);
        i_rd_round = v.rk_round;
        #1;
        check("rk_valid", o_rd_valid, 1'b1);
        check("rk_value", o_rd_key, v.rk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit found;
        vecs[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10, -1,
                    6'd4, 32'ha0fafe17, 6'd43, 32'hb6630ca6, 6'd7, 32'h2a6c7605,
                    4'd1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 6, 12, -1,
                    6'd6, 32'hfe0c91f7, 6'd51, 32'h01002202, 6'd9, 32'h6c827f6b,
                    4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8, 14, 20,
                    6'd8, 32'h9ba35411, 6'd12, 32'ha8b09c1a, 6'd59, 32'h706c631e,
                    4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde};

        @(negedge clk);
        check("reset_outputs", {o_ready, o_done, o_err, o_wvalid, o_widx, o_w, o_rd_valid},
              {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0});
        rst = 1'b0;

        for (int vi = 0; vi < 3; vi++) apply_vec(vi);

        i_valid = 1'b1;
        i_mode  = 2'd3;
        @(negedge clk);
        i_valid    = 1'b0;
        i_rd_round = 4'd0;
        #1;
        check("err_pulse", {o_err, o_wvalid, o_done, o_ready}, 4'b1001);
        check("err_rd_invalid", o_rd_valid, 1'b0);
        @(negedge clk);
        check("err_single", {o_err, o_wvalid, o_done}, 3'b000);

        i_valid = 1'b1;
        i_mode  = 2'd2;
        i_key   = vecs[2].key;
        @(negedge clk);
        i_valid = 1'b0;
        found   = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (o_wvalid && o_widx == 6'd20) found = 1'b1;
        end
        check("reach_w20", found, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_expand", {o_ready, o_done, o_err, o_wvalid, o_widx, o_w, o_rd_valid},
              {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0});
        @(negedge clk);
        check("rst_held", {o_ready, o_done, o_err, o_wvalid, o_widx, o_w, o_rd_valid},
              {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0});
        rst = 1'b0;
        apply_vec(0);

        i_rd_round = 4'd10;
        #1;
        check("rd10_valid", o_rd_valid, 1'b1);
        check("rd10_key", o_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        i_rd_round = 4'd11;
        #1;
        check("rd11_invalid", o_rd_valid, 1'b0);
        i_rd_round = 4'd0;
        #1;
        check("rd0_key", o_rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
